hsv_colour_bbox: RTL and testbench

//  Consumes the per-pixel HSV stream from the colour-space stage and classifies each pixel

---
 rtl/hsv_colour_bbox_if.sv | 23 ++
 rtl/hsv_colour_bbox.sv | 239 +++++++++++++++++++++++
 tb/tb_hsv_colour_bbox.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hsv_colour_bbox_if.sv
// Frame-result channel from the colour bounding-box block to the nav/UART side.
// master : drives the result (res_valid plus the res_* payload) and samples res_ready
// slave  : samples the result and drives res_ready
interface hsv_colour_bbox_if;
    logic        res_valid;
    logic        res_ready;
    logic        res_found;
    logic [10:0] res_xmin;
    logic [10:0] res_xmax;
    logic [9:0]  res_ymin;
    logic [9:0]  res_ymax;
    logic [19:0] res_count;

    modport master (
        output res_valid, res_found, res_xmin, res_xmax, res_ymin, res_ymax, res_count,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_found, res_xmin, res_xmax, res_ymin, res_ymax, res_count,
        output res_ready
    );
endinterface

// File: rtl/hsv_colour_bbox.sv
// Classifies each HSV pixel against a programmable window, with hue wrap-around for red.
// Accumulates the bounding box and match count of the matching pixels over one frame,
// then offers one result per frame on a valid/ready channel.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   valid_in, sop, eop          pixel strobe, first and last pixel of the frame
//   hsv_h, hsv_s, hsv_v         pixel hue (0..359), saturation, value
//   h_lo, h_hi, s_min, v_min    match window, sampled on the sop pixel
//   match_out, match_vld        per-pixel classification, one cycle after valid_in
//   overrun                     one-cycle pulse when an unread result is overwritten
//   res (master)                frame result: valid/ready, found, box, count
//
// state  | meaning
// IDLE   | waiting for a sop pixel, other pixels ignored
// ACCUM  | inside a frame, accumulating matches
// REPORT | one cycle, publishes the accumulators into the result registers
module hsv_colour_bbox #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int MIN_COUNT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic       sop,
    input  logic       eop,
    input  logic [8:0] hsv_h,
    input  logic [7:0] hsv_s,
    input  logic [7:0] hsv_v,
    input  logic [8:0] h_lo,
    input  logic [8:0] h_hi,
    input  logic [7:0] s_min,
    input  logic [7:0] v_min,
    output logic       match_out,
    output logic       match_vld,
    output logic       overrun,
    hsv_colour_bbox_if.master res
);

    localparam logic [10:0] X_LAST  = 11'(IMG_W - 1);
    localparam logic [9:0]  Y_LAST  = 10'(IMG_H - 1);
    localparam logic [19:0] CNT_MAX = '1;
    localparam logic [19:0] MIN_CNT = 20'(MIN_COUNT);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t state, state_nxt;
    logic   load;

    logic [8:0] thr_h_lo, thr_h_hi;
    logic [7:0] thr_s_min, thr_v_min;
    logic [8:0] win_h_lo, win_h_hi;
    logic [7:0] win_s_min, win_v_min;
    logic       frame_start, accum_pix, hue_ok, pix_match;

    logic [10:0] pos_x, cur_x, nxt_x;
    logic [9:0]  pos_y, cur_y, nxt_y;

    logic [10:0] acc_xmin, acc_xmax, base_xmin, base_xmax, upd_xmin, upd_xmax;
    logic [9:0]  acc_ymin, acc_ymax, base_ymin, base_ymax, upd_ymin, upd_ymax;
    logic [19:0] acc_count, base_count, upd_count;

    logic        res_valid_q, res_found_q;
    logic [10:0] res_xmin_q, res_xmax_q;
    logic [9:0]  res_ymin_q, res_ymax_q;
    logic [19:0] res_count_q;

    // Classification. The sop pixel is judged against the window presented with it,
    // every later pixel against the copy latched on sop.
    always_comb begin
        frame_start = valid_in & sop;
        accum_pix   = frame_start | (valid_in & (state == ACCUM));
        if (frame_start) begin
            win_h_lo  = h_lo;
            win_h_hi  = h_hi;
            win_s_min = s_min;
            win_v_min = v_min;
        end else begin
            win_h_lo  = thr_h_lo;
            win_h_hi  = thr_h_hi;
            win_s_min = thr_s_min;
            win_v_min = thr_v_min;
        end
        if (win_h_lo <= win_h_hi)
            hue_ok = (hsv_h >= win_h_lo) && (hsv_h <= win_h_hi);
        else
            hue_ok = (hsv_h >= win_h_lo) || (hsv_h <= win_h_hi);
        pix_match = hue_ok && (hsv_s >= win_s_min) && (hsv_v >= win_v_min);
    end

    // pos_x/pos_y hold the coordinate the next pixel will take; sop forces (0,0).
    always_comb begin
        cur_x = sop ? '0 : pos_x;
        cur_y = sop ? '0 : pos_y;
        if (cur_x == X_LAST) begin
            nxt_x = '0;
            nxt_y = (cur_y == Y_LAST) ? cur_y : cur_y + 10'd1;
        end else begin
            nxt_x = cur_x + 11'd1;
            nxt_y = cur_y;
        end
    end

    // A sop pixel starts from cleared accumulators, so an aborted frame simply vanishes.
    always_comb begin
        if (sop) begin
            base_xmin  = X_LAST;
            base_xmax  = '0;
            base_ymin  = Y_LAST;
            base_ymax  = '0;
            base_count = '0;
        end else begin
            base_xmin  = acc_xmin;
            base_xmax  = acc_xmax;
            base_ymin  = acc_ymin;
            base_ymax  = acc_ymax;
            base_count = acc_count;
        end
        upd_xmin  = base_xmin;
        upd_xmax  = base_xmax;
        upd_ymin  = base_ymin;
        upd_ymax  = base_ymax;
        upd_count = base_count;
        if (pix_match) begin
            if (cur_x < base_xmin) upd_xmin = cur_x;
            if (cur_x > base_xmax) upd_xmax = cur_x;
            if (cur_y < base_ymin) upd_ymin = cur_y;
            if (cur_y > base_ymax) upd_ymax = cur_y;
            if (base_count != CNT_MAX) upd_count = base_count + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            thr_h_lo  <= '0;
            thr_h_hi  <= '0;
            thr_s_min <= '0;
            thr_v_min <= '0;
            pos_x     <= '0;
            pos_y     <= '0;
            acc_xmin  <= X_LAST;
            acc_xmax  <= '0;
            acc_ymin  <= Y_LAST;
            acc_ymax  <= '0;
            acc_count <= '0;
            match_out <= 1'b0;
            match_vld <= 1'b0;
        end else begin
            if (frame_start) begin
                thr_h_lo  <= h_lo;
                thr_h_hi  <= h_hi;
                thr_s_min <= s_min;
                thr_v_min <= v_min;
            end
            if (accum_pix) begin
                pos_x     <= nxt_x;
                pos_y     <= nxt_y;
                acc_xmin  <= upd_xmin;
                acc_xmax  <= upd_xmax;
                acc_ymin  <= upd_ymin;
                acc_ymax  <= upd_ymax;
                acc_count <= upd_count;
            end
            match_vld <= valid_in;
            match_out <= valid_in & pix_match;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A sop arriving during REPORT opens the next frame straight away so back-to-back
    // frames are not lost; REPORT still publishes the previous frame's accumulators.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = eop ? REPORT : ACCUM;
            end
            ACCUM: begin
                if (valid_in && eop) state_nxt = REPORT;
            end
            REPORT: begin
                load = 1'b1;
                if (frame_start) state_nxt = eop ? REPORT : ACCUM;
                else             state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A load wins over an accept in the same cycle, so res_valid then stays high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            res_xmin_q  <= '0;
            res_xmax_q  <= '0;
            res_ymin_q  <= '0;
            res_ymax_q  <= '0;
            res_count_q <= '0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                res_valid_q <= 1'b1;
                overrun     <= res_valid_q & ~res.res_ready;
                res_found_q <= (acc_count >= MIN_CNT);
                res_count_q <= acc_count;
                if (acc_count == '0) begin
                    res_xmin_q <= '0;
                    res_xmax_q <= '0;
                    res_ymin_q <= '0;
                    res_ymax_q <= '0;
                end else begin
                    res_xmin_q <= acc_xmin;
                    res_xmax_q <= acc_xmax;
                    res_ymin_q <= acc_ymin;
                    res_ymax_q <= acc_ymax;
                end
            end else if (res_valid_q && res.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign res.res_valid = res_valid_q;
    assign res.res_found = res_found_q;
    assign res.res_xmin  = res_xmin_q;
    assign res.res_xmax  = res_xmax_q;
    assign res.res_ymin  = res_ymin_q;
    assign res.res_ymax  = res_ymax_q;
    assign res.res_count = res_count_q;

endmodule

// File: tb/tb_hsv_colour_bbox.sv
// Directed bench for hsv_colour_bbox on a 4x4 image (MIN_COUNT 16).
module tb_hsv_colour_bbox;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in, sop, eop;
    logic [8:0] hsv_h, h_lo, h_hi;
    logic [7:0] hsv_s, hsv_v, s_min, v_min;
    logic       match_out, match_vld, overrun;

    int n_checks = 0;
    int n_errors = 0;

    hsv_colour_bbox_if rif ();

    hsv_colour_bbox #(.IMG_W(4), .IMG_H(4), .MIN_COUNT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sop       (sop),
        .eop       (eop),
        .hsv_h     (hsv_h),
        .hsv_s     (hsv_s),
        .hsv_v     (hsv_v),
        .h_lo      (h_lo),
        .h_hi      (h_hi),
        .s_min     (s_min),
        .v_min     (v_min),
        .match_out (match_out),
        .match_vld (match_vld),
        .overrun   (overrun),
        .res       (rif)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         sop;
        logic [8:0] h;
        logic [7:0] s, v;
        logic [8:0] lo, hi;
        logic [7:0] smin, vmin;
        bit         exp;
    } cls_vec_t;

    cls_vec_t vecs[17];

    function automatic cls_vec_t mk(input bit sp, input int h, input int s, input int v,
                                    input int lo, input int hi, input int smin,
                                    input int vmin, input bit e);
        cls_vec_t t;
        t.sop  = sp;
        t.h    = 9'(h);
        t.s    = 8'(s);
        t.v    = 8'(v);
        t.lo   = 9'(lo);
        t.hi   = 9'(hi);
        t.smin = 8'(smin);
        t.vmin = 8'(vmin);
        t.exp  = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] res_pack();
        return {rif.res_valid, rif.res_found, rif.res_xmin, rif.res_xmax,
                rif.res_ymin, rif.res_ymax, rif.res_count};
    endfunction

    function automatic logic [63:0] er(input bit f, input int x0, input int x1,
                                       input int y0, input int y1, input int c);
        return {1'b1, f, 11'(x0), 11'(x1), 10'(y0), 10'(y1), 20'(c)};
    endfunction

    task automatic set_win(input int lo, input int hi, input int smin, input int vmin);
        h_lo  = 9'(lo);
        h_hi  = 9'(hi);
        s_min = 8'(smin);
        v_min = 8'(vmin);
    endtask

    // Pixel i matches (h=15) when mask[i] is set, otherwise h=100. Returns on the
    // falling edge right after the last pixel was sampled.
    task automatic frame(input int n, input logic [31:0] mask, input bit with_sop,
                         input bit with_eop);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            sop      = with_sop && (i == 0);
            eop      = with_eop && (i == n - 1);
            hsv_h    = mask[i] ? 9'd15 : 9'd100;
            hsv_s    = 8'd100;
            hsv_v    = 8'd100;
        end
        @(negedge clk);
        valid_in = 1'b0;
        sop      = 1'b0;
        eop      = 1'b0;
    endtask

    task automatic pix_chk(input cls_vec_t t, input int idx);
        @(negedge clk);
        valid_in = 1'b1;
        sop      = t.sop;
        eop      = 1'b0;
        hsv_h    = t.h;
        hsv_s    = t.s;
        hsv_v    = t.v;
        set_win(int'(t.lo), int'(t.hi), int'(t.smin), int'(t.vmin));
        @(negedge clk);
        chk($sformatf("match[%0d]", idx), {62'd0, match_vld, match_out}, {62'd0, 1'b1, t.exp});
        valid_in = 1'b0;
        sop      = 1'b0;
    endtask

    task automatic accept(input string name);
        rif.res_ready = 1'b1;
        @(negedge clk);
        chk(name, {63'd0, rif.res_valid}, 64'd0);
        rif.res_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(1,  15, 100, 100,  10,  20,  50,  50, 1);
        vecs[1]  = mk(1,  10, 100, 100,  10,  20,  50,  50, 1);
        vecs[2]  = mk(1,  20, 100, 100,  10,  20,  50,  50, 1);
        vecs[3]  = mk(1,   9, 100, 100,  10,  20,  50,  50, 0);
        vecs[4]  = mk(1,  21, 100, 100,  10,  20,  50,  50, 0);
        vecs[5]  = mk(1,  15,  49, 100,  10,  20,  50,  50, 0);
        vecs[6]  = mk(1,  15,  50,  50,  10,  20,  50,  50, 1);
        vecs[7]  = mk(1,  15, 100,  49,  10,  20,  50,  50, 0);
        vecs[8]  = mk(0,  15, 100, 100, 100, 200, 200, 200, 1);
        vecs[9]  = mk(0, 150, 100, 100, 100, 200,   0,   0, 0);
        vecs[10] = mk(1, 350, 100, 100, 340,  20,  50,  50, 1);
        vecs[11] = mk(0,   5, 100, 100, 340,  20,  50,  50, 1);
        vecs[12] = mk(0, 180, 100, 100, 340,  20,  50,  50, 0);
        vecs[13] = mk(1, 340, 100, 100, 340,  20,   0,   0, 1);
        vecs[14] = mk(1,  21, 100, 100, 340,  20,   0,   0, 0);
        vecs[15] = mk(1, 339, 100, 100, 340,  20,   0,   0, 0);
        vecs[16] = mk(1,  20,   0,   0, 340,  20,   0,   0, 1);

        rst_n = 1'b0;
        valid_in = 1'b0; sop = 1'b0; eop = 1'b0;
        hsv_h = '0; hsv_s = '0; hsv_v = '0;
        set_win(0, 0, 0, 0);
        rif.res_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_res", res_pack(), 64'd0);
        chk("reset_pix", {61'd0, match_out, match_vld, overrun}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Classification table
        foreach (vecs[i]) pix_chk(vecs[i], i);
        @(negedge clk);
        chk("match_vld_idle", {63'd0, match_vld}, 64'd0);

        // 4x4 frame, matches at (1,1) and (2,3)
        set_win(10, 20, 50, 50);
        frame(16, 32'h0000_4020, 1, 1);
        chk("t2_latency", {63'd0, rif.res_valid}, 64'd0);
        @(negedge clk);
        chk("t2_result", res_pack(), er(0, 1, 2, 1, 3, 2));
        accept("t2_accept");

        // y saturates on the last line: pixel 18 lands on (2,3)
        frame(20, 32'h0004_0000, 1, 1);
        chk("ysat_latency", {63'd0, rif.res_valid}, 64'd0);
        @(negedge clk);
        chk("ysat_result", res_pack(), er(0, 2, 2, 3, 3, 1));
        accept("ysat_accept");

        // Aborted frame: 7 matching pixels, then a fresh sop
        frame(7, 32'h0000_007F, 1, 0);
        chk("abort_no_result", {63'd0, rif.res_valid}, 64'd0);
        frame(16, 32'h0000_0840, 1, 1);
        chk("abort_latency", {63'd0, rif.res_valid}, 64'd0);
        @(negedge clk);
        chk("abort_result", res_pack(), er(0, 2, 3, 1, 2, 2));
        accept("abort_accept");

        // Overrun: two frames without reading
        frame(16, 32'h0000_0001, 1, 1);
        @(negedge clk);
        chk("ovr_first", res_pack(), er(0, 0, 0, 0, 0, 1));
        frame(16, 32'h0000_8200, 1, 1);
        chk("ovr_stable", res_pack(), er(0, 0, 0, 0, 0, 1));
        chk("ovr_pre", {63'd0, overrun}, 64'd0);
        @(negedge clk);
        chk("ovr_second", res_pack(), er(0, 1, 3, 2, 3, 2));
        chk("ovr_pulse", {63'd0, overrun}, 64'd1);
        @(negedge clk);
        chk("ovr_pulse_end", {62'd0, rif.res_valid, overrun}, 64'd2);
        accept("ovr_accept");

        // No-match frame, then a full-match frame loaded on the same cycle it is accepted
        frame(16, 32'h0000_0000, 1, 1);
        @(negedge clk);
        chk("nomatch_result", res_pack(), er(0, 0, 0, 0, 0, 0));
        frame(16, 32'h0000_FFFF, 1, 1);
        rif.res_ready = 1'b1;
        @(negedge clk);
        chk("full_result", res_pack(), er(1, 0, 3, 0, 3, 16));
        chk("full_no_overrun", {63'd0, overrun}, 64'd0);
        @(negedge clk);
        chk("full_accept", {63'd0, rif.res_valid}, 64'd0);
        rif.res_ready = 1'b0;

        // Reset mid-frame with a result pending
        frame(16, 32'h0000_0020, 1, 1);
        @(negedge clk);
        chk("rst_pending", {63'd0, rif.res_valid}, 64'd1);
        frame(4, 32'h0000_000F, 1, 0);
        rst_n    = 1'b0;
        valid_in = 1'b1;
        hsv_h    = 9'd15;
        repeat (5) @(negedge clk);
        chk("rst_mid_res", res_pack(), 64'd0);
        chk("rst_mid_pix", {61'd0, match_out, match_vld, overrun}, 64'd0);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        frame(16, 32'h0000_FFFF, 0, 1);
        repeat (3) @(negedge clk);
        chk("rst_needs_sop", {63'd0, rif.res_valid}, 64'd0);
        frame(16, 32'h0000_0400, 1, 1);
        chk("rst_latency", {63'd0, rif.res_valid}, 64'd0);
        @(negedge clk);
        chk("rst_next_frame", res_pack(), er(0, 2, 2, 2, 2, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
